// File: rtl/cpu_bus_arb.sv
// Purpose : shares the single CPU bus master port between IF fetches and MEM-stage accesses.
// Latency : 5 cycles strobe-to-release minimum; each grant or ready wait cycle adds one.
// Backpres: requesters stall on X_busy; the arbiter waits on bus_grnt_ and bus_rdy_ without timeout.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   stall, flush             pipeline stall (holds DONE) and flush (drops or discards the access)
//   if_as_, if_addr          IF read strobe (active-low) and word address
//   if_rd_data, if_busy      IF read result register and stall request
//   mem_as_, mem_rw,         MEM strobe (active-low), READ=1/WRITE=0,
//   mem_addr, mem_wr_data    word address and write data
//   mem_rd_data, mem_busy    MEM read result register and stall request
//   bus_req_, bus_grnt_      bus request/grant handshake (active-low)
//   bus_as_, bus_rw,         bus address strobe (one cycle, active-low), direction,
//   bus_addr, bus_wr_data    word address and write data (held REQ..WAIT)
//   bus_rd_data, bus_rdy_    bus read data and ready (active-low)
module cpu_bus_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        if_as_,
  input  logic [29:0] if_addr,
  output logic [31:0] if_rd_data,
  output logic        if_busy,
  input  logic        mem_as_,
  input  logic        mem_rw,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        mem_busy,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
);

  localparam logic READ = 1'b1;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_ACCESS, ST_WAIT, ST_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt;
  logic        flush_seen, flush_seen_nxt;
  logic        req_nxt, as_nxt, rw_nxt;
  logic [29:0] addr_nxt;
  logic [31:0] wd_nxt, if_rd_nxt, mem_rd_nxt;
  logic        flush_hit;

  // A flush arriving after bus_as_ cannot abort the bus cycle; remember it
  // so the completed result is dropped instead of handed to the pipeline.
  assign flush_hit = flush_seen | flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      owner       <= OWN_MEM;
      flush_seen  <= 1'b0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      if_rd_data  <= '0;
      mem_rd_data <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      flush_seen  <= flush_seen_nxt;
      bus_req_    <= req_nxt;
      bus_as_     <= as_nxt;
      bus_rw      <= rw_nxt;
      bus_addr    <= addr_nxt;
      bus_wr_data <= wd_nxt;
      if_rd_data  <= if_rd_nxt;
      mem_rd_data <= mem_rd_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    flush_seen_nxt = flush_seen;
    req_nxt        = bus_req_;
    as_nxt         = bus_as_;
    rw_nxt         = bus_rw;
    addr_nxt       = bus_addr;
    wd_nxt         = bus_wr_data;
    if_rd_nxt      = if_rd_data;
    mem_rd_nxt     = mem_rd_data;

    case (state)
      ST_IDLE: begin
        flush_seen_nxt = 1'b0;
        // MEM has fixed priority: the older instruction must make progress.
        if (!mem_as_) begin
          owner_nxt = OWN_MEM;
          addr_nxt  = mem_addr;
          rw_nxt    = mem_rw;
          wd_nxt    = mem_wr_data;
          req_nxt   = 1'b0;
          state_nxt = ST_REQ;
        end else if (!if_as_) begin
          owner_nxt = OWN_IF;
          addr_nxt  = if_addr;
          rw_nxt    = READ;
          wd_nxt    = '0;
          req_nxt   = 1'b0;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush) begin
          req_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!bus_grnt_) begin
          as_nxt    = 1'b0;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        as_nxt         = 1'b1;
        flush_seen_nxt = flush_hit;
        state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        flush_seen_nxt = flush_hit;
        if (!bus_rdy_) begin
          req_nxt        = 1'b1;
          flush_seen_nxt = 1'b0;
          if (flush_hit) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DONE;
            if (bus_rw == READ) begin
              if (owner == OWN_MEM) mem_rd_nxt = bus_rd_data;
              else                  if_rd_nxt  = bus_rd_data;
            end
          end
        end
      end
      ST_DONE: begin
        if (flush || !stall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Busy drops only in DONE for the owner; a waiting non-owner stays stalled.
  assign if_busy  = ~if_as_  & ~(state == ST_DONE && owner == OWN_IF);
  assign mem_busy = ~mem_as_ & ~(state == ST_DONE && owner == OWN_MEM);

endmodule

// File: doc/cpu_bus_arb.md
# cpu_bus_arb

CPU-side bus arbiter and sequencer sharing the single CPU bus master port between the instruction fetch stage (IF) and the memory access stage (MEM). It accepts the combinational access strobes produced by the fetch logic and by the MEM-stage memory controller (active-low address strobe, read/write, word address, write data), wins the system bus through the request/grant handshake, runs one word transaction, and returns read data plus a busy signal the pipeline uses to stall. It sits between the CPU pipeline stages and the bus master interface of the AZPR bus.

## Interface
- No parameters; widths come from `WordAddrBus` (30 bits) and `WordDataBus` (32 bits). Encodings: `READ`=1, `WRITE`=0, strobes active-low.
- Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  global pipeline stall
- flush  in  1  pipeline flush
- if_as_  in  1  IF access strobe (read only)
- if_addr  in  30  IF word address
- if_rd_data  out  32  IF read data
- if_busy  out  1  IF must stall
- mem_as_  in  1  MEM access strobe
- mem_rw  in  1  MEM read/write
- mem_addr  in  30  MEM word address
- mem_wr_data  in  32  MEM write data
- mem_rd_data  out  32  MEM read data
- mem_busy  out  1  MEM must stall
- bus_req_  out  1  bus request
- bus_grnt_  in  1  bus grant
- bus_as_  out  1  bus address strobe
- bus_rw  out  1  bus read/write
- bus_addr  out  30  bus word address
- bus_wr_data  out  32  bus write data
- bus_rd_data  in  32  bus read data
- bus_rdy_  in  1  bus ready

## Operation
- States: IDLE, REQ, ACCESS, WAIT, DONE. Owner register (IF/MEM) latched on leaving IDLE.
- IDLE: if mem_as_=0, owner=MEM; else if if_as_=0, owner=IF (MEM fixed priority). Latch owner's addr, rw (IF forces READ), wr_data into bus_addr/bus_rw/bus_wr_data; set bus_req_=0; go REQ. No request: stay.
- REQ: bus_grnt_=0 -> bus_as_=0, go ACCESS. flush=1 -> bus_req_=1, go IDLE (flush wins over grant).
- ACCESS: bus_as_=1 (strobe exactly one cycle), go WAIT.
- WAIT: bus_rdy_=0 -> capture bus_rd_data into owner's rd_data register (reads only; writes leave it unchanged), bus_req_=1; go DONE, or IDLE if flush was seen at any point in ACCESS/WAIT (transaction completes on bus, result discarded). No abort once bus_as_ issued.
- DONE: owner's busy=0 this cycle; stays in DONE while stall=1; stall=0 -> IDLE. flush -> IDLE.
- Busy (combinational): X_busy = ~X_as_ & ~(state==DONE & owner==X). Non-owner requester sees busy=1 whenever its strobe is low.
- A strobe still low when IDLE is re-entered is a new transaction.
- rd_data outputs are registers, held until next capture for that requester.
- Reset (async): state IDLE, owner MEM, bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0, bus_wr_data=0, if_rd_data=0, mem_rd_data=0, flush-seen=0.

## Timing
- Strobe low in cycle 0 (IDLE) -> bus_req_ low from cycle 1; grant sampled in cycle 1 -> bus_as_ low cycle 2; rdy_ in cycle 3 -> DONE cycle 4, busy low cycle 4. Minimum 5 cycles, busy high cycles 0-3.
- Each extra cycle of grant or ready delay adds one cycle; no timeout.
- Simultaneous IF and MEM in IDLE: MEM served first; IF served starting the IDLE after MEM's DONE.
- bus_addr/bus_rw/bus_wr_data stable from REQ through WAIT; requester changes during that window ignored.
- Reset mid-transaction: bus signals return to idle immediately, no completion.

## Test plan
- MEM read addr 0x0000_0010, grant immediate, rdy_ in WAIT first cycle with data 0xDEADBEEF -> bus_as_ low exactly cycle 2, mem_busy high cycles 0-3, mem_rd_data=0xDEADBEEF from cycle 4.
- MEM write 0x12345678 to addr 0x40 with grant delayed 3 cycles -> bus_rw=0, bus_wr_data=0x12345678, bus_as_ low once in cycle 5, mem_rd_data unchanged.
- IF and MEM strobes both low in IDLE -> MEM transaction first, if_busy high throughout, IF bus_as_ issued after MEM DONE, both rd_data correct.
- stall=1 held 3 cycles during DONE -> no second bus_as_, mem_busy low all 3 cycles, IDLE after stall drops.
- flush in REQ -> bus_req_ high next cycle, no bus_as_; flush in WAIT -> transaction finishes on rdy_, rd_data unchanged, no DONE.
- reset asserted in WAIT -> bus_req_=1, bus_as_=1, rd_data=0 asynchronously, state IDLE.
